// File: rtl/board_fill_engine.sv
// rtl/board_fill_engine.sv - row-major board fill sweeper with cursor writes; `POP_COUNT_EN adds live_count
module board_fill_engine #(
    parameter int                MAP_WIDTH  = 8,
    parameter int                MAP_HEIGHT = 8,
    parameter int                ADDR_W     = 8,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
    parameter int                SEED       = 825
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              op_start,
    input  logic [1:0]        op_sel,
    input  logic              abort,
    input  logic              cur_set,
    input  logic              cur_clr,
    input  logic [ADDR_W-1:0] cur_x,
    input  logic [ADDR_W-1:0] cur_y,
    output logic [ADDR_W-1:0] pat_addrC,
    output logic [ADDR_W-1:0] pat_addrR,
    input  logic              pat_data,
    input  logic              wr_ready,
    output logic              write_en,
    output logic              write_data,
    output logic [ADDR_W-1:0] wAddrC,
    output logic [ADDR_W-1:0] wAddrR,
    output logic              busy,
`ifdef POP_COUNT_EN
    output logic [2*ADDR_W:0] live_count,
`endif
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_CUR,
        S_DONE
    } state_t;

    localparam logic [1:0] SEL_CLEAR   = 2'b00;
    localparam logic [1:0] SEL_FILL    = 2'b01;
    localparam logic [1:0] SEL_RANDOM  = 2'b10;
    localparam logic [1:0] SEL_PATTERN = 2'b11;

    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(MAP_WIDTH - 1);
    localparam logic [ADDR_W-1:0] LAST_R = ADDR_W'(MAP_HEIGHT - 1);
    localparam logic [LFSR_W-1:0] SEED_V = LFSR_W'(SEED);
    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [LFSR_W-1:0] SEED_INIT =
        (SEED_V == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED_V;

    state_t            state;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;
    logic [1:0]        sel;
    logic [LFSR_W-1:0] lfsr;

    logic              last_col;
    logic              last_cell;
    logic [ADDR_W-1:0] nxt_col;
    logic [ADDR_W-1:0] nxt_row;
    logic              accept;
    logic [LFSR_W-1:0] lfsr_shift;

    assign last_col   = (col == LAST_C);
    assign last_cell  = last_col && (row == LAST_R);
    assign nxt_col    = last_col ? '0 : col + 1'b1;
    assign nxt_row    = last_col ? row + 1'b1 : row;
    assign accept     = (state == S_WRITE) && wr_ready;
    assign lfsr_shift = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};

    function automatic logic src_bit(input logic [1:0] s, input logic rnd);
        case (s)
            SEL_CLEAR:  src_bit = 1'b0;
            SEL_FILL:   src_bit = 1'b1;
            SEL_RANDOM: src_bit = rnd;
            default:    src_bit = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            col        <= '0;
            row        <= '0;
            sel        <= SEL_CLEAR;
            lfsr       <= SEED_INIT;
            pat_addrC  <= '0;
            pat_addrR  <= '0;
            write_en   <= 1'b0;
            write_data <= 1'b0;
            wAddrC     <= '0;
            wAddrR     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef POP_COUNT_EN
            live_count <= '0;
`endif
        end else begin
            done <= 1'b0;
            // An aborted-but-accepted random write still consumes its LFSR bit.
            if (accept && sel == SEL_RANDOM) begin
                lfsr <= lfsr_shift;
            end
`ifdef POP_COUNT_EN
            if (accept && write_data) begin
                live_count <= live_count + 1'b1;
            end
`endif
            case (state)
                S_IDLE: begin
                    if (!mode) begin
                        if (op_start) begin
                            sel  <= op_sel;
                            col  <= '0;
                            row  <= '0;
                            busy <= 1'b1;
`ifdef POP_COUNT_EN
                            live_count <= '0;
`endif
                            if (op_sel == SEL_PATTERN) begin
                                state     <= S_FETCH;
                                pat_addrC <= '0;
                                pat_addrR <= '0;
                            end else begin
                                state      <= S_WRITE;
                                write_en   <= 1'b1;
                                wAddrC     <= '0;
                                wAddrR     <= '0;
                                write_data <= src_bit(op_sel, lfsr[0]);
                            end
                        end else if (cur_set || cur_clr) begin
                            state      <= S_CUR;
                            write_en   <= 1'b1;
                            wAddrC     <= cur_x;
                            wAddrR     <= cur_y;
                            write_data <= cur_set;
                        end
                    end
                end
                S_CUR: begin
                    if (wr_ready) begin
                        state      <= S_IDLE;
                        write_en   <= 1'b0;
                        write_data <= 1'b0;
                        wAddrC     <= '0;
                        wAddrR     <= '0;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        col   <= '0;
                        row   <= '0;
                    end else begin
                        state      <= S_WRITE;
                        write_en   <= 1'b1;
                        wAddrC     <= col;
                        wAddrR     <= row;
                        write_data <= pat_data;
                    end
                end
                S_WRITE: begin
                    if (abort || (wr_ready && last_cell)) begin
                        state      <= abort ? S_IDLE : S_DONE;
                        done       <= !abort;
                        busy       <= 1'b0;
                        write_en   <= 1'b0;
                        write_data <= 1'b0;
                        wAddrC     <= '0;
                        wAddrR     <= '0;
                        col        <= '0;
                        row        <= '0;
                    end else if (wr_ready) begin
                        col <= nxt_col;
                        row <= nxt_row;
                        if (sel == SEL_PATTERN) begin
                            state     <= S_FETCH;
                            write_en  <= 1'b0;
                            pat_addrC <= nxt_col;
                            pat_addrR <= nxt_row;
                        end else begin
                            wAddrC     <= nxt_col;
                            wAddrR     <= nxt_row;
                            write_data <= src_bit(sel, lfsr_shift[0]);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_fill_engine.sv
// tb/tb_board_fill_engine.sv - scoreboard bench for board_fill_engine (8x8 default build)
module tb_board_fill_engine;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          op_start;
    logic [1:0]    op_sel;
    logic          abort;
    logic          cur_set;
    logic          cur_clr;
    logic [AW-1:0] cur_x;
    logic [AW-1:0] cur_y;
    logic [AW-1:0] pat_addrC;
    logic [AW-1:0] pat_addrR;
    logic          pat_data;
    logic          wr_ready;
    logic          write_en;
    logic          write_data;
    logic [AW-1:0] wAddrC;
    logic [AW-1:0] wAddrR;
    logic          busy;
    logic          done;
`ifdef POP_COUNT_EN
    logic [2*AW:0] live_count;
`endif

    board_fill_engine dut (
        .clk(clk), .rst(rst), .mode(mode), .op_start(op_start), .op_sel(op_sel),
        .abort(abort), .cur_set(cur_set), .cur_clr(cur_clr), .cur_x(cur_x), .cur_y(cur_y),
        .pat_addrC(pat_addrC), .pat_addrR(pat_addrR), .pat_data(pat_data),
        .wr_ready(wr_ready), .write_en(write_en), .write_data(write_data),
        .wAddrC(wAddrC), .wAddrR(wAddrR), .busy(busy),
`ifdef POP_COUNT_EN
        .live_count(live_count),
`endif
        .done(done)
    );

    typedef struct packed {
        logic [7:0] c;
        logic [7:0] r;
        logic       d;
    } wr_t;

    wr_t         exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cycle = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          busy_cyc = 0;
    int          first_acc = -1;
    int          last_acc = -1;
    int          done_cyc = -1;
    int          start_cyc = 0;
    int          rdy_mode = 0;
    logic        hold_pend = 1'b0;
    wr_t         hold_val;
    logic [7:0]  rom [8];
    logic [15:0] lfsr_m = 16'd825;
    logic        pat_exp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign pat_data = rom[pat_addrR[2:0]][3'd7 - pat_addrC[2:0]];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) wr_ready = 1'b1;
            else if (rdy_mode == 1) wr_ready = cycle[0];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                done_cyc = cycle;
            end
            if (write_en) begin
                if (hold_pend)
                    check("hold_stable", int'({wAddrC, wAddrR, write_data}), int'(hold_val));
                if (wr_ready) begin
                    acc_cnt++;
                    if (first_acc < 0) first_acc = cycle;
                    last_acc  = cycle;
                    hold_pend = 1'b0;
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_write: got col %0d row %0d data %0d expected no write",
                                 wAddrC, wAddrR, write_data);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_col", wAddrC, e.c);
                        check("wr_row", wAddrR, e.r);
                        check("wr_data", write_data, e.d);
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_val  = {wAddrC, wAddrR, write_data};
                end
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    task automatic clear_stats();
        acc_cnt = 0; done_cnt = 0; busy_cyc = 0;
        first_acc = -1; last_acc = -1; done_cyc = -1;
    endtask

    task automatic push_sweep(input int kind);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                wr_t e;
                e.c = 8'(c);
                e.r = 8'(r);
                case (kind)
                    0: e.d = 1'b0;
                    1: e.d = 1'b1;
                    2: begin
                        e.d    = lfsr_m[0];
                        lfsr_m = {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
                    end
                    default: e.d = pat_exp[c];
                endcase
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_op(input logic [1:0] s);
        @(posedge clk);
        #1;
        op_sel    = s;
        op_start  = 1'b1;
        start_cyc = cycle;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        op_sel   = 2'b00;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: no done within %0d cycles, expected 1 pulse", name, budget);
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input int budget, input string name);
        int n = 0;
        while (acc_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (acc_cnt < target) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got %0d accepts expected %0d", name, acc_cnt, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = 8'hA5;
        rst = 1'b0; mode = 1'b0; op_start = 1'b0; op_sel = 2'b00; abort = 1'b0;
        cur_set = 1'b0; cur_clr = 1'b0; cur_x = '0; cur_y = '0; wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_write_en", write_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_waddr", int'({wAddrC, wAddrR}), 0);
        check("rst_pataddr", int'({pat_addrC, pat_addrR}), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // clear sweep, ready always high
        clear_stats();
        push_sweep(0);
        start_op(2'b00);
        wait_done(200, "clear");
        check("clear_accepts", acc_cnt, 64);
        check("clear_done_cnt", done_cnt, 1);
        check("clear_first_write", first_acc, start_cyc + 1);
        check("clear_last_write", last_acc, start_cyc + 64);
        check("clear_done_cycle", done_cyc, last_acc + 1);
        check("clear_busy_cycles", busy_cyc, 64);
        check("clear_busy_after", busy, 0);

        // random sweep twice: sequence continues without reseeding
        for (int k = 0; k < 2; k++) begin
            clear_stats();
            push_sweep(2);
            start_op(2'b10);
            wait_done(200, "random");
            check("random_accepts", acc_cnt, 64);
            check("random_done_cnt", done_cnt, 1);
            check("random_queue_empty", exp_q.size(), 0);
        end

        // pattern sweep
        clear_stats();
        push_sweep(3);
        start_op(2'b11);
        wait_done(400, "pattern");
        check("pattern_accepts", acc_cnt, 64);
        check("pattern_done_cnt", done_cnt, 1);
        check("pattern_first_write", first_acc, start_cyc + 2);
        check("pattern_busy_cycles", busy_cyc, 128);

        // fill with ready low every other cycle
        clear_stats();
        rdy_mode = 1;
        push_sweep(1);
        start_op(2'b01);
        wait_done(400, "fill");
        rdy_mode = 0;
        check("fill_accepts", acc_cnt, 64);
        check("fill_done_cnt", done_cnt, 1);
        check("fill_done_cycle", done_cyc, last_acc + 1);
`ifdef POP_COUNT_EN
        check("fill_live_count", int'(live_count), 64);
`endif

        // abort after the 10th accept
        clear_stats();
        for (int c = 0; c < 8; c++) exp_q.push_back({8'(c), 8'd0, 1'b0});
        exp_q.push_back({8'd0, 8'd1, 1'b0});
        exp_q.push_back({8'd1, 8'd1, 1'b0});
        start_op(2'b00);
        wait_acc(10, 50, "abort_wait");
        @(posedge clk);
        #2;
        rdy_mode = 2;
        wr_ready = 1'b0;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        wr_ready = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        check("abort_write_en", write_en, 0);
        check("abort_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_accepts", acc_cnt, 10);
        exp_q.delete();
        clear_stats();
        push_sweep(0);
        start_op(2'b00);
        wait_done(200, "after_abort");
        check("after_abort_accepts", acc_cnt, 64);

        // cursor writes and the run-mode interlock
        clear_stats();
        @(posedge clk);
        #1;
        mode = 1'b1; cur_set = 1'b1; cur_x = 8'd3; cur_y = 8'd5;
        repeat (4) @(negedge clk);
        check("runmode_write_en", write_en, 0);
        check("runmode_accepts", acc_cnt, 0);
        exp_q.push_back({8'd3, 8'd5, 1'b1});
        @(posedge clk);
        #1;
        mode = 1'b0; cur_clr = 1'b1;
        @(posedge clk);
        #1;
        cur_set = 1'b0; cur_clr = 1'b0;
        repeat (4) @(negedge clk);
        check("cursor_accepts", acc_cnt, 1);
        check("cursor_queue_empty", exp_q.size(), 0);

        // reset in the middle of a sweep
        clear_stats();
        push_sweep(1);
        start_op(2'b01);
        wait_acc(5, 50, "reset_wait");
        rst = 1'b0;
        #1;
        check("midrst_write_en", write_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        exp_q.delete();
        hold_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_idle_write_en", write_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/board_fill_engine.md
Name: board_fill_engine

Overview:
Parametrised successor to the edit-mode board writer. It sweeps the cell board row-major and writes one of four fill sources: clear, fill-all, LFSR random, or an external pattern ROM. It also services single-cell cursor writes. Unlike the previous generation it adds a write-ready handshake, abort, a run-mode interlock, a selectable source, a configurable LFSR and a done pulse. It sits between the edit-command decoder and the cell-board write port.

Parameters:
MAP_WIDTH, 8, board columns (1..2^ADDR_W)
MAP_HEIGHT, 8, board rows (1..2^ADDR_W)
ADDR_W, 8, width of every column/row address
LFSR_W, 16, random generator width (>=3)
LFSR_TAPS, 16'hB400, Fibonacci tap mask, bit i = stage i+1 (default x^16+x^14+x^13+x^11+1)
SEED, 825, LFSR reset value; 0 is replaced by 1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
mode  in  1  1 = run/evolve, 0 = edit
op_start  in  1  start sweep (sampled in IDLE only)
op_sel  in  2  00 clear, 01 fill, 10 random, 11 pattern
abort  in  1  terminate sweep
cur_set  in  1  write 1 at cursor
cur_clr  in  1  write 0 at cursor
cur_x  in  ADDR_W  cursor column
cur_y  in  ADDR_W  cursor row
pat_addrC  out  ADDR_W  pattern ROM column
pat_addrR  out  ADDR_W  pattern ROM row
pat_data  in  1  ROM bit, valid 1 cycle after address
wr_ready  in  1  board accepts write this cycle
write_en  out  1  write request
write_data  out  1  cell value
wAddrC  out  ADDR_W  write column
wAddrR  out  ADDR_W  write row
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset: state IDLE; all outputs 0; traversal counters 0; LFSR = SEED; op_sel latch = 00. Reset mid-sweep discards the sweep with no done pulse.
- States: IDLE, FETCH, WRITE, CUR, DONE. All outputs are registered. busy = 1 in FETCH and WRITE.
- IDLE with mode=1: op_start, cur_set and cur_clr are ignored.
- IDLE with mode=0: priority is op_start, then cur_set, then cur_clr.
  - op_start latches op_sel and clears the counters. Next state is FETCH for pattern, WRITE otherwise.
  - cur_set/cur_clr go to CUR with wAddr = (cur_x, cur_y) and data 1 or 0. If both are high, cur_set wins.
- CUR: write_en = 1 and held until wr_ready, then IDLE. abort has no effect on CUR.
- FETCH (pattern only): pat_addr = current cell; next cycle goes to WRITE with data = pat_data.
- WRITE: write_en = 1; wAddr, write_data and source stay stable until a cycle with wr_ready = 1 (accept).
  - Data source: clear = 0, fill = 1, random = LFSR[0].
  - LFSR shifts left with feedback = XOR-reduce(LFSR & LFSR_TAPS), only on an accepted random write.
- On accept:
  - At the last cell (MAP_WIDTH-1, MAP_HEIGHT-1): go to DONE.
  - Else, column at MAP_WIDTH-1: column = 0, row + 1.
  - Else: column + 1.
  - Then go to FETCH (pattern) or WRITE.
- DONE: done = 1 for one cycle, counters reset, then IDLE.
- abort in FETCH or WRITE: next state IDLE, no done pulse, counters reset. Abort wins over a simultaneous accept; that write is still counted as accepted by the board.
- op_start, op_sel and mode changes during a sweep are ignored; the sweep completes.
- Latency with wr_ready held at 1:
  - clear/fill/random: first write_en in cycle 1 after op_start; MAP_WIDTH*MAP_HEIGHT write cycles; done one cycle after the last accept.
  - pattern: 2 cycles per cell.
- MAP_WIDTH = 1 or MAP_HEIGHT = 1 must traverse correctly. A 1x1 board gives one write, then done.

Optional Feature:
POP_COUNT_EN
- Defined: adds output live_count [2*ADDR_W:0]. It clears at sweep start and increments on each accepted write with data 1. It holds after done/abort; cursor writes do not change it.
- Undefined: no port, no counter logic.

Test Plan:
- 8x8, op_sel=00, wr_ready=1: pulse op_start → 64 consecutive write_en cycles, data 0, addresses (0,0)..(7,7) row-major; done high exactly once, 1 cycle after the 64th write; busy low afterwards.
- op_sel=10 after reset, SEED=825: first 16 write_data bits match a golden LFSR model. Repeat the sweep → the sequence continues without reseeding.
- op_sel=11, ROM row r = 8'hA5 for every r: two cycles per cell; write_data per row = 1,0,1,0,0,1,0,1; 128 cycles to done.
- op_sel=01, wr_ready low every other cycle → each address is held until accepted; still 64 accepts and 1 done. With POP_COUNT_EN, live_count = 64.
- Abort after the 10th accept → IDLE next cycle, no done. A following clear starts at (0,0).
- mode=1 with cur_set=1 → no write. Then mode=0, cur_set and cur_clr both high at (3,5) → one write of 1 at column 3, row 5. Assert rst low mid-sweep → outputs 0 immediately.
